// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin write-side arbiter that lets N_REQ valid/ready
// requesters share the shift_in/in write port of one register-based FIFO.
// A grant lasts up to MAX_BURST beats, ends early when the owner stops offering
// beats, and simply stalls (without releasing) while the FIFO is full.
module fifo_wr_arbiter #(
    parameter int WIDTH     = 4,
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 4,
    parameter int ID_W      = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   res,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
    input  logic                   fifo_full,
    output logic                   fifo_shift_in,
    output logic [WIDTH-1:0]       fifo_in,
    output logic [ID_W-1:0]        grant_id,
    output logic                   busy
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t          r_state;
    logic [ID_W-1:0] r_owner;
    logic [ID_W-1:0] r_rr_ptr;
    logic [3:0]      r_beat_cnt;

    logic            w_found;
    logic [ID_W-1:0] w_sel;
    logic [ID_W-1:0] w_idx;
    logic            w_owner_valid;
    logic [WIDTH-1:0] w_owner_data;
    logic            w_open;
    logic            w_xfer;
    logic            w_last_beat;
    logic            w_release;
    logic [ID_W-1:0] w_next_rr;

    // Round-robin search: first valid requester starting at rr_ptr, wrapping at N_REQ-1.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = r_rr_ptr;
        for (int k = 0; k < N_REQ; k++) begin
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
            w_idx = (w_idx == ID_W'(N_REQ - 1)) ? '0 : w_idx + 1'b1;
        end
    end

    // Select the owner's data slice and valid bit.
    always_comb begin
        w_owner_data  = '0;
        w_owner_valid = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_owner == ID_W'(i)) begin
                w_owner_data  = req_data[i*WIDTH +: WIDTH];
                w_owner_valid = req_valid[i];
            end
        end
    end

    // The write port is open only in GRANT, out of reset, with room in the FIFO.
    assign w_open      = (r_state == ST_GRANT) && !res && !fifo_full;
    assign w_xfer      = w_open && w_owner_valid;
    assign w_last_beat = (r_beat_cnt == 4'(MAX_BURST - 1));
    // An absent beat releases even while the FIFO is full; a full FIFO alone never does.
    assign w_release   = (w_xfer && w_last_beat) || !w_owner_valid;
    assign w_next_rr   = (r_owner == ID_W'(N_REQ - 1)) ? '0 : r_owner + 1'b1;

    // Ready goes only to the owner, so at most one bit is ever set.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_ready[i] = w_open && (r_owner == ID_W'(i));
        end
    end

    assign fifo_shift_in = w_xfer;
    assign fifo_in       = w_owner_data;
    assign grant_id      = r_owner;
    assign busy          = (r_state == ST_GRANT);

    // Grant FSM: arbitrate in IDLE, count beats and decide release in GRANT.
    always_ff @(posedge clk) begin
        if (res) begin
            r_state    <= ST_IDLE;
            r_owner    <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_state    <= ST_GRANT;
                        r_owner    <= w_sel;
                        r_beat_cnt <= '0;
                    end
                end
                ST_GRANT: begin
                    if (w_release) begin
                        r_state    <= ST_IDLE;
                        r_rr_ptr   <= w_next_rr;
                        r_beat_cnt <= '0;
                    end else if (w_xfer) begin
                        r_beat_cnt <= r_beat_cnt + 4'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus randomized traffic, all
// compared against a transaction-level reference model of the arbitration rules.
module tb_fifo_wr_arbiter;

    localparam int WIDTH     = 4;
    localparam int N_REQ     = 4;
    localparam int MAX_BURST = 4;
    localparam int ID_W      = 2;

    logic                   clk = 1'b0;
    logic                   res;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*WIDTH-1:0] req_data;
    logic [N_REQ-1:0]       req_ready;
    logic                   fifo_full;
    logic                   fifo_shift_in;
    logic [WIDTH-1:0]       fifo_in;
    logic [ID_W-1:0]        grant_id;
    logic                   busy;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .WIDTH    (WIDTH),
        .N_REQ    (N_REQ),
        .MAX_BURST(MAX_BURST)
    ) dut (
        .clk          (clk),
        .res          (res),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .fifo_shift_in(fifo_shift_in),
        .fifo_in      (fifo_in),
        .grant_id     (grant_id),
        .busy         (busy)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: who holds the port, how many beats it has written, where the search starts.
    bit m_busy;
    int m_owner;
    int m_rr;
    int m_beats;

    // Directed traffic sources: beats left and next data value per requester.
    int rem[N_REQ];
    int dcnt[N_REQ];

    // Observation logs (from the DUT) for end-of-scenario comparisons.
    int  wlog_d[$];
    int  wlog_c[$];
    int  glog[$];
    bit  prev_busy;
    bit  last_shift;
    int  last_owner;
    int  ed[8];
    int  ec[8];
    int  c0;
    int  nwin;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    task automatic step(input bit rst, input logic [N_REQ-1:0] v, input bit full,
                        input logic [N_REQ*WIDTH-1:0] d);
        logic [N_REQ-1:0] e_rdy;
        bit               e_shift;
        logic [WIDTH-1:0] e_data;
        bit               found;
        int               idx;
        @(negedge clk);
        res       = rst;
        req_valid = v;
        fifo_full = full;
        req_data  = d;
        #1;
        e_rdy   = '0;
        e_shift = 1'b0;
        e_data  = d[m_owner*WIDTH +: WIDTH];
        if (!rst && m_busy && !full) begin
            e_rdy[m_owner] = 1'b1;
            e_shift        = v[m_owner];
        end
        check_eq("req_ready", 32'(req_ready), 32'(e_rdy));
        check_eq("fifo_shift_in", 32'(fifo_shift_in), 32'(e_shift));
        check_eq("busy", 32'(busy), 32'(m_busy));
        check_eq("grant_id", 32'(grant_id), 32'(m_owner));
        if (e_shift) check_eq("fifo_in", 32'(fifo_in), 32'(e_data));
        check_eq("write_while_full", 32'(fifo_shift_in && fifo_full), 32'd0);
        check_eq("multi_ready", 32'($countones(req_ready) > 1), 32'd0);

        if (busy && !prev_busy) glog.push_back(int'(grant_id));
        prev_busy = busy;
        if (fifo_shift_in) begin
            wlog_d.push_back(int'(fifo_in));
            wlog_c.push_back(cyc);
        end
        last_shift = e_shift;
        last_owner = m_owner;

        if (rst) begin
            m_busy = 0; m_owner = 0; m_rr = 0; m_beats = 0;
        end else if (!m_busy) begin
            found = 0;
            for (int k = 0; k < N_REQ; k++) begin
                idx = (m_rr + k) % N_REQ;
                if (!found && v[idx]) begin
                    found = 1; m_busy = 1; m_owner = idx; m_beats = 0;
                end
            end
        end else begin
            if (e_shift) m_beats++;
            if (m_beats == MAX_BURST || !v[m_owner]) begin
                m_busy = 0;
                m_rr   = (m_owner + 1) % N_REQ;
            end
        end
        cyc++;
    endtask

    // Directed cycle: requesters with beats left are valid and show their next data value.
    task automatic dstep(input bit rst, input bit full);
        logic [N_REQ-1:0]       v;
        logic [N_REQ*WIDTH-1:0] d;
        for (int i = 0; i < N_REQ; i++) begin
            v[i]               = (rem[i] > 0);
            d[i*WIDTH +: WIDTH] = WIDTH'(dcnt[i]);
        end
        step(rst, v, full, d);
        if (last_shift) begin
            rem[last_owner]--;
            dcnt[last_owner]++;
        end
    endtask

    task automatic start_scenario();
        for (int i = 0; i < N_REQ; i++) begin
            rem[i] = 0; dcnt[i] = 0;
        end
        dstep(1, 0);
        wlog_d.delete(); wlog_c.delete(); glog.delete();
    endtask

    // Compare the first n logged writes to ed[] (data) and ec[] (cycle offset from first write).
    task automatic check_log(input string tag, input int n);
        check_eq({tag, "_count"}, 32'(wlog_d.size()), 32'(n));
        for (int k = 0; k < n; k++) begin
            if (k < wlog_d.size()) begin
                check_eq({tag, "_data"}, 32'(wlog_d[k]), 32'(ed[k]));
                check_eq({tag, "_cycle"}, 32'(wlog_c[k] - wlog_c[0]), 32'(ec[k]));
            end
        end
    endtask

    initial begin
        res = 1'b1; req_valid = '0; req_data = '0; fifo_full = 1'b0;
        m_busy = 0; m_owner = 0; m_rr = 0; m_beats = 0; prev_busy = 0;
        last_shift = 0; last_owner = 0;

        // Scenario 1: single requester, 6 beats -> 4-beat burst, one IDLE cycle, 2 beats.
        start_scenario();
        dstep(0, 0);
        rem[0] = 6;
        repeat (12) dstep(0, 0);
        ed = '{0, 1, 2, 3, 4, 5, 0, 0};
        ec = '{0, 1, 2, 3, 5, 6, 0, 0};
        check_log("s1", 6);
        check_eq("s1_grants", 32'(glog.size()), 32'd2);
        if (glog.size() >= 2) check_eq("s1_grant1", 32'(glog[1]), 32'd0);

        // Scenario 2: all four always valid -> order 0,1,2,3,0 and 16 writes per 20 cycles.
        start_scenario();
        for (int i = 0; i < N_REQ; i++) rem[i] = 1000;
        c0 = cyc;
        repeat (41) dstep(0, 0);
        check_eq("s2_grants", 32'(glog.size() >= 5), 32'd1);
        for (int k = 0; k < 5; k++)
            if (k < glog.size()) check_eq("s2_order", 32'(glog[k]), 32'(k % N_REQ));
        nwin = 0;
        foreach (wlog_c[k]) if (wlog_c[k] >= c0 + 1 && wlog_c[k] <= c0 + 20) nwin++;
        check_eq("s2_throughput", 32'(nwin), 32'd16);
        for (int i = 0; i < N_REQ; i++) rem[i] = 0;
        repeat (3) dstep(0, 0);

        // Scenario 3: requester 2, FIFO full for 3 cycles mid-burst.
        start_scenario();
        rem[2] = 4;
        dstep(0, 0);
        dstep(0, 0);
        dstep(0, 0);
        repeat (3) dstep(0, 1);
        repeat (4) dstep(0, 0);
        ed = '{0, 1, 2, 3, 0, 0, 0, 0};
        ec = '{0, 1, 5, 6, 0, 0, 0, 0};
        check_log("s3", 4);
        check_eq("s3_grants", 32'(glog.size()), 32'd1);
        if (glog.size() >= 1) check_eq("s3_owner", 32'(glog[0]), 32'd2);

        // Scenario 4: requester 1 drops after 2 beats, requester 3 waiting.
        start_scenario();
        rem[1] = 2; rem[3] = 4;
        repeat (11) dstep(0, 0);
        ed = '{0, 1, 0, 1, 2, 3, 0, 0};
        ec = '{0, 1, 4, 5, 6, 7, 0, 0};
        check_log("s4", 6);
        check_eq("s4_grants", 32'(glog.size()), 32'd2);
        if (glog.size() >= 2) begin
            check_eq("s4_first", 32'(glog[0]), 32'd1);
            check_eq("s4_second", 32'(glog[1]), 32'd3);
        end

        // Scenario 5: reset during beat 2 of requester 3's burst, then 1 and 3 compete.
        start_scenario();
        rem[3] = 10;
        dstep(0, 0);
        dstep(0, 0);
        dstep(0, 0);
        rem[1] = 10;
        dstep(1, 0);
        dstep(0, 0);
        check_eq("s5_busy_after_rst", 32'(busy), 32'd0);
        check_eq("s5_gid_after_rst", 32'(grant_id), 32'd0);
        repeat (3) dstep(0, 0);
        check_eq("s5_writes_before_rst", 32'(wlog_d.size() >= 2), 32'd1);
        check_eq("s5_grants", 32'(glog.size()), 32'd2);
        if (glog.size() >= 2) begin
            check_eq("s5_first", 32'(glog[0]), 32'd3);
            check_eq("s5_after_rst", 32'(glog[1]), 32'd1);
        end

        // Scenario 6: random valid, data, full and occasional reset.
        dstep(1, 0);
        repeat (3000) begin
            step(($urandom_range(0, 199) == 0),
                 N_REQ'($urandom),
                 ($urandom_range(0, 3) == 0),
                 (N_REQ*WIDTH)'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
